axi4_lite_slv_reg_bank: RTL and testbench
=========================================

Name: axi4_lite_slv_reg_bank

Overview:
- AXI4-Lite responder (slave) exposing four 32-bit registers to a bus master: control, free-running cycle counter, scratch, and read-only ID.
- Sits between the AXI4-Lite interconnect or test-bench master and user logic.
- CTRL drives user logic via o_ctrl.
- Replaces ad-hoc slave templates with a fully handshaked, back-pressure-correct register bank.

Parameters:
- AXI4_LITE_ADDR_BIT_WIDTH, 4, address bus width; byte address; word index = addr[3:2].
- AXI4_LITE_DATA_BIT_WIDTH, 32, data bus width; only 32 is supported; elaboration-time $fatal otherwise.
- CTRL_RST_VAL, 32'h0000_0000, reset value of CTRL.
- ID_VAL, 32'h4D43_0001, constant returned by ID.

Ports:
- i_clk  input  1  clock.
- i_async_rst_n  input  1  reset; asynchronous assert, active-low; the design synchronises de-assertion externally.
- if_s_axi4_lite  modport  axi4_lite_if.slv_port  AXI4-Lite slave port: aw*, w*, b*, ar*, r* channels; widths per parameters.
- o_ctrl  output  32  current CTRL register value.

Behaviour:
- Register map (addr[3:2]):
  - 0 CTRL: RW, honours wstrb.
  - 1 CNT: increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; any write clears it to 0 regardless of wstrb.
  - 2 SCRATCH: RW, honours wstrb.
  - 3 ID: RO.
- Ignored inputs: addr[1:0], awprot and arprot.
- Reset (i_async_rst_n=0) outputs:
  - awready=wready=arready=0, bvalid=0, rvalid=0, bresp=rresp=2'b00, rdata=0.
  - CTRL=CTRL_RST_VAL, SCRATCH=0, CNT=0.
- First cycle after reset release: awready=wready=arready=1.
- Write path, AW and W captured independently, each into its own one-entry slot:
  - awready = AW slot empty && !bvalid.
  - wready = W slot empty && !bvalid.
  - AW and W can arrive in either order or on the same edge.
- Write commit:
  - On the first edge k where both slots are full, the write commits: registers update at edge k, slots clear, and bvalid=1 with bresp from edge k.
  - AW+W handshake on the same edge j: commit at edge j+1; bvalid visible in cycle after j+1.
  - bvalid and bresp hold until the bready handshake; slots accept new AW/W only after bvalid drops.
- Write response:
  - bresp=2'b10 (SLVERR) for a write to ID; the register is unchanged.
  - All other writes: 2'b00 (OKAY).
  - wstrb=0 is a legal no-op write with OKAY (CNT is still cleared).
- Read path:
  - arready = !rvalid.
  - AR handshake at edge k: rdata registered at edge k and rvalid=1 from edge k, rresp=OKAY.
  - rdata and rvalid hold stable until rready.
  - A new AR is accepted on the edge after rvalid&&rready.
- CNT read returns the counter value sampled at the AR handshake edge.
- Read/write collision: a read sampled on the same edge as a write commit to the same register returns the pre-write value.
- Counter vs. write: a CNT clear takes priority over the increment on the same edge.
- Reset mid-transaction: all slots, pending bvalid and rvalid are discarded immediately (async); no response is ever issued for aborted transactions.
- Read and write channels are fully independent; no ordering between them.

Decomposition:
- Package axi4_lite_reg_bank_pkg contains:
  - AXI resp localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Register index enum REG_CTRL/REG_CNT/REG_SCRATCH/REG_ID (2-bit).
  - Default ID value.
- One sub-module, axi4_lite_chan_slot: a one-entry valid/ready holding register, parameterised by payload width. It is instantiated for AW (addr) and W (data+strb).

Test Plan:
- Reset check: hold i_async_rst_n=0 for 3 cycles, then release. Required: all valid/ready outputs 0 during reset; awready=wready=arready=1 one cycle after release; read addr 0xC returns 32'h4D43_0001 with OKAY.
- AW first, W 3 cycles later: AW 0x0, then W 32'h1234_5678, wstrb 4'hF. Required: bvalid 1 cycle after the W handshake, bresp OKAY, o_ctrl=32'h1234_5678.
- Partial strobe: SCRATCH holds 32'hFFFF_FFFF; write 32'h0000_00AB with wstrb 4'b0001 to 0x8. Required: readback 32'hFFFF_FFAB.
- Write to ID: write 32'hDEAD_BEEF to 0xC. Required: bresp 2'b10; ID still reads 32'h4D43_0001.
- Back-pressure:
  - bready=0 for 5 cycles after the write. Required: bvalid, bresp stable; awready=wready=0 throughout.
  - rready=0 for 4 cycles on a CNT read. Required: rdata frozen; arready=0 until the handshake.
- Counter and reset abort:
  - Write CNT, read CNT 10 cycles later. Required: value in 9..11 as per the stated latency rule (exactly 10 in the lock-step bench).
  - Assert reset during a pending bvalid. Required: bvalid drops immediately; no B response afterwards; CTRL back to 0.

Source files
------------

// File: rtl/axi4_lite_reg_bank_pkg.sv
// Shared types and constants for the AXI4-Lite register bank.
package axi4_lite_reg_bank_pkg;

    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned REG_STRB_W = REG_DATA_W / 8;
    localparam int unsigned REG_IDX_W  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [REG_DATA_W-1:0] ID_VAL_DEFAULT = 32'h4D43_0001;

    typedef enum logic [REG_IDX_W-1:0] {
        REG_CTRL    = 2'd0,
        REG_CNT     = 2'd1,
        REG_SCRATCH = 2'd2,
        REG_ID      = 2'd3
    } reg_idx_e;

    typedef struct packed {
        logic [REG_DATA_W-1:0] data;
        logic [REG_STRB_W-1:0] strb;
    } w_beat_t;

    // Byte-lane merge of a write beat into an existing register value.
    function automatic logic [REG_DATA_W-1:0] apply_wstrb(
        input logic [REG_DATA_W-1:0] old_val,
        input logic [REG_DATA_W-1:0] new_val,
        input logic [REG_STRB_W-1:0] strb
    );
        logic [REG_DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < int'(REG_STRB_W); b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport mst_port (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slv_port (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_chan_slot.sv
// One-entry holding slot for a valid/ready channel; cleared by the consumer.
module axi4_lite_chan_slot #(
    parameter int unsigned PAYLOAD_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 accept_en,
    input  logic                 clr,
    output logic                 ready_c,
    output logic                 full,
    output logic [PAYLOAD_W-1:0] payload
);

    logic                 full_q, full_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;

    assign ready_c = ~full_q & accept_en;
    assign full    = full_q;
    assign payload = payload_q;

    // Fill on handshake, empty on consumer clear.
    always_comb begin
        full_d    = full_q;
        payload_d = payload_q;
        if (full_q) begin
            if (clr) full_d = 1'b0;
        end else if (in_valid && accept_en) begin
            full_d    = 1'b1;
            payload_d = in_payload;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            full_q    <= full_d;
            payload_q <= payload_d;
        end
    end

endmodule

// File: rtl/axi4_lite_slv_reg_bank.sv
// AXI4-Lite slave with CTRL / CNT / SCRATCH / ID registers.
module axi4_lite_slv_reg_bank
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int unsigned           AXI4_LITE_ADDR_BIT_WIDTH = 4,
    parameter int unsigned           AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter logic [REG_DATA_W-1:0] CTRL_RST_VAL             = 32'h0000_0000,
    parameter logic [REG_DATA_W-1:0] ID_VAL                   = ID_VAL_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_async_rst_n,
    axi4_lite_if.slv_port         if_s_axi4_lite,
    output logic [REG_DATA_W-1:0] o_ctrl
);

    if (AXI4_LITE_DATA_BIT_WIDTH != 32) begin : g_bad_data_w
        $fatal(1, "axi4_lite_slv_reg_bank: only 32-bit data is supported");
    end
    if (AXI4_LITE_ADDR_BIT_WIDTH < 4) begin : g_bad_addr_w
        $fatal(1, "axi4_lite_slv_reg_bank: address must be at least 4 bits");
    end

    localparam int unsigned W_BEAT_W = $bits(w_beat_t);

    logic                  rdy_en_q, rdy_en_d;
    logic [REG_DATA_W-1:0] ctrl_q, ctrl_d;
    logic [REG_DATA_W-1:0] cnt_q, cnt_d;
    logic [REG_DATA_W-1:0] scratch_q, scratch_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [REG_DATA_W-1:0] rdata_q, rdata_d;

    logic                  aw_ready_c, aw_full;
    logic [REG_IDX_W-1:0]  aw_payload;
    logic                  w_ready_c, w_full;
    logic [W_BEAT_W-1:0]   w_payload;
    w_beat_t               w_in, w_beat;
    reg_idx_e              aw_idx, ar_idx;
    logic                  slot_en_c, commit_c, ar_hs_c, arready_c;
    logic                  unused_bits;

    assign slot_en_c = rdy_en_q & ~bvalid_q;
    assign commit_c  = aw_full & w_full;
    assign w_in      = '{data: if_s_axi4_lite.wdata, strb: if_s_axi4_lite.wstrb};
    assign w_beat    = w_beat_t'(w_payload);
    assign aw_idx    = reg_idx_e'(aw_payload);
    assign ar_idx    = reg_idx_e'(if_s_axi4_lite.araddr[3:2]);
    assign arready_c = rdy_en_q & ~rvalid_q;
    assign ar_hs_c   = if_s_axi4_lite.arvalid & arready_c;

    axi4_lite_chan_slot #(.PAYLOAD_W(REG_IDX_W)) u_aw_slot (
        .clk        (i_clk),
        .rst_n      (i_async_rst_n),
        .in_valid   (if_s_axi4_lite.awvalid),
        .in_payload (if_s_axi4_lite.awaddr[3:2]),
        .accept_en  (slot_en_c),
        .clr        (commit_c),
        .ready_c    (aw_ready_c),
        .full       (aw_full),
        .payload    (aw_payload)
    );

    axi4_lite_chan_slot #(.PAYLOAD_W(W_BEAT_W)) u_w_slot (
        .clk        (i_clk),
        .rst_n      (i_async_rst_n),
        .in_valid   (if_s_axi4_lite.wvalid),
        .in_payload (W_BEAT_W'(w_in)),
        .accept_en  (slot_en_c),
        .clr        (commit_c),
        .ready_c    (w_ready_c),
        .full       (w_full),
        .payload    (w_payload)
    );

    // Register updates, write commit/response and read capture.
    always_comb begin
        rdy_en_d  = 1'b1;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q + 32'd1;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (bvalid_q && if_s_axi4_lite.bready) bvalid_d = 1'b0;
        if (commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            unique case (aw_idx)
                REG_CTRL:    ctrl_d    = apply_wstrb(ctrl_q, w_beat.data, w_beat.strb);
                REG_CNT:     cnt_d     = '0;
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, w_beat.data, w_beat.strb);
                REG_ID:      bresp_d   = RESP_SLVERR;
            endcase
        end

        if (rvalid_q && if_s_axi4_lite.rready) rvalid_d = 1'b0;
        if (ar_hs_c) begin
            rvalid_d = 1'b1;
            unique case (ar_idx)
                REG_CTRL:    rdata_d = ctrl_q;
                REG_CNT:     rdata_d = cnt_q;
                REG_SCRATCH: rdata_d = scratch_q;
                REG_ID:      rdata_d = ID_VAL;
            endcase
        end
    end

    // State registers; reset discards any in-flight response.
    always_ff @(posedge i_clk or negedge i_async_rst_n) begin
        if (!i_async_rst_n) begin
            rdy_en_q  <= 1'b0;
            ctrl_q    <= CTRL_RST_VAL;
            cnt_q     <= '0;
            scratch_q <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign if_s_axi4_lite.awready = aw_ready_c;
    assign if_s_axi4_lite.wready  = w_ready_c;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = bresp_q;
    assign if_s_axi4_lite.arready = arready_c;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = RESP_OKAY;
    assign o_ctrl                 = ctrl_q;

    // Address low bits and protection attributes carry no meaning here.
    assign unused_bits = ^{if_s_axi4_lite.awaddr, if_s_axi4_lite.araddr,
                           if_s_axi4_lite.awprot, if_s_axi4_lite.arprot};

endmodule

// File: tb/tb_axi4_lite_slv_reg_bank.sv
// Randomised lock-step bench for the AXI4-Lite register bank.
module tb_axi4_lite_slv_reg_bank;

    localparam logic [31:0] ID_EXP = 32'h4D43_0001;

    logic        i_clk;
    logic        i_async_rst_n;
    logic [31:0] o_ctrl;

    axi4_lite_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    axi4_lite_slv_reg_bank dut (
        .i_clk          (i_clk),
        .i_async_rst_n  (i_async_rst_n),
        .if_s_axi4_lite (bus),
        .o_ctrl         (o_ctrl)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference state: register contents and the edge at which CNT last read 0.
    int          n_cmp = 0;
    int          n_err = 0;
    int          edge_n = 0;
    int          clr_edge = 0;
    int          aw_edge, w_edge, ar_edge;
    logic [31:0] m_ctrl = 32'h0;
    logic [31:0] m_scratch = 32'h0;
    logic [1:0]  exp_bresp;
    logic [31:0] last_rdata;

    always @(posedge i_clk) edge_n <= edge_n + 1;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr, input int e);
        case (addr[3:2])
            2'd0:    return m_ctrl;
            2'd1:    return 32'(e - 1 - clr_edge);
            2'd2:    return m_scratch;
            default: return ID_EXP;
        endcase
    endfunction

    task automatic send_aw(input logic [3:0] addr);
        int n;
        @(negedge i_clk);
        bus.awvalid = 1'b1;
        bus.awaddr  = addr;
        bus.awprot  = 3'($urandom);
        n = 0;
        while (bus.awready !== 1'b1 && n < 64) begin @(negedge i_clk); n++; end
        if (n == 64) chk_eq("aw_timeout", 32'(bus.awready), 32'd1);
        @(negedge i_clk);
        aw_edge = edge_n;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge i_clk);
        bus.wvalid = 1'b1;
        bus.wdata  = data;
        bus.wstrb  = strb;
        n = 0;
        while (bus.wready !== 1'b1 && n < 64) begin @(negedge i_clk); n++; end
        if (n == 64) chk_eq("w_timeout", 32'(bus.wready), 32'd1);
        @(negedge i_clk);
        w_edge = edge_n;
        bus.wvalid = 1'b0;
    endtask

    // Issue AW/W with independent lead-in delays; ends on the cycle bvalid shows.
    task automatic wr_issue(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly);
        int k;
        fork
            begin repeat (aw_dly) @(negedge i_clk); send_aw(addr); end
            begin repeat (w_dly) @(negedge i_clk); send_w(data, strb); end
        join
        k = ((aw_edge > w_edge) ? aw_edge : w_edge) + 1;
        chk_eq("bvalid_before_commit", 32'(bus.bvalid), 32'd0);
        @(negedge i_clk);
        exp_bresp = 2'b00;
        case (addr[3:2])
            2'd0: m_ctrl = merge(m_ctrl, data, strb);
            2'd1: clr_edge = k;
            2'd2: m_scratch = merge(m_scratch, data, strb);
            default: exp_bresp = 2'b10;
        endcase
        chk_eq("bvalid", 32'(bus.bvalid), 32'd1);
        chk_eq("bresp", 32'(bus.bresp), 32'(exp_bresp));
        chk_eq("o_ctrl", o_ctrl, m_ctrl);
    endtask

    task automatic wr_finish(input int bdly);
        for (int i = 0; i < bdly; i++) begin
            chk_eq("bvalid_hold", 32'(bus.bvalid), 32'd1);
            chk_eq("bresp_hold", 32'(bus.bresp), 32'(exp_bresp));
            chk_eq("awready_blocked", 32'(bus.awready), 32'd0);
            chk_eq("wready_blocked", 32'(bus.wready), 32'd0);
            @(negedge i_clk);
        end
        bus.bready = 1'b1;
        @(negedge i_clk);
        bus.bready = 1'b0;
        chk_eq("bvalid_drop", 32'(bus.bvalid), 32'd0);
        chk_eq("awready_back", 32'(bus.awready), 32'd1);
    endtask

    task automatic rd(input logic [3:0] addr, input int rdly);
        int n;
        logic [31:0] exp;
        @(negedge i_clk);
        bus.arvalid = 1'b1;
        bus.araddr  = addr;
        bus.arprot  = 3'($urandom);
        n = 0;
        while (bus.arready !== 1'b1 && n < 64) begin @(negedge i_clk); n++; end
        if (n == 64) chk_eq("ar_timeout", 32'(bus.arready), 32'd1);
        @(negedge i_clk);
        ar_edge = edge_n;
        bus.arvalid = 1'b0;
        exp = model_read(addr, ar_edge);
        last_rdata = bus.rdata;
        chk_eq("rvalid", 32'(bus.rvalid), 32'd1);
        chk_eq("rdata", bus.rdata, exp);
        chk_eq("rresp", 32'(bus.rresp), 32'd0);
        for (int i = 0; i < rdly; i++) begin
            @(negedge i_clk);
            chk_eq("rdata_hold", bus.rdata, exp);
            chk_eq("arready_blocked", 32'(bus.arready), 32'd0);
        end
        bus.rready = 1'b1;
        @(negedge i_clk);
        bus.rready = 1'b0;
        chk_eq("rvalid_drop", 32'(bus.rvalid), 32'd0);
        chk_eq("arready_back", 32'(bus.arready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_async_rst_n = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.rready  = 1'b0;

        // Reset values and first cycle after release.
        repeat (3) @(negedge i_clk);
        chk_eq("rst_awready", 32'(bus.awready), 32'd0);
        chk_eq("rst_wready", 32'(bus.wready), 32'd0);
        chk_eq("rst_arready", 32'(bus.arready), 32'd0);
        chk_eq("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk_eq("rst_rdata", bus.rdata, 32'd0);
        chk_eq("rst_ctrl", o_ctrl, 32'd0);
        i_async_rst_n = 1'b1;
        clr_edge = edge_n;
        @(negedge i_clk);
        chk_eq("rel_awready", 32'(bus.awready), 32'd1);
        chk_eq("rel_wready", 32'(bus.wready), 32'd1);
        chk_eq("rel_arready", 32'(bus.arready), 32'd1);
        rd(4'hC, 0);
        chk_eq("id_read", last_rdata, ID_EXP);

        // AW first, W three cycles later.
        wr_issue(4'h0, 32'h1234_5678, 4'hF, 0, 3);
        chk_eq("ctrl_write", o_ctrl, 32'h1234_5678);
        wr_finish(0);

        // W first, then AW; and both together.
        wr_issue(4'h8, 32'hFFFF_FFFF, 4'hF, 2, 0);
        wr_finish(1);
        wr_issue(4'h9, 32'h0000_00AB, 4'b0001, 0, 0);
        wr_finish(0);
        rd(4'h8, 0);
        chk_eq("scratch_partial", last_rdata, 32'hFFFF_FFAB);

        // Write to ID is rejected.
        wr_issue(4'hC, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk_eq("id_slverr", 32'(bus.bresp), 32'd2);
        wr_finish(0);
        rd(4'hC, 0);
        chk_eq("id_unchanged", last_rdata, ID_EXP);

        // Back-pressure on B and R.
        wr_issue(4'h0, 32'hCAFE_0001, 4'hF, 1, 1);
        wr_finish(5);
        rd(4'h4, 4);

        // Counter cleared, read ten cycles later.
        wr_issue(4'h4, 32'h0, 4'h0, 0, 0);
        wr_finish(0);
        while (edge_n < clr_edge + 9) @(negedge i_clk);
        rd(4'h4, 0);
        chk_eq("cnt_10", last_rdata, 32'd10);

        // Random mix of reads and writes.
        for (int t = 0; t < 60; t++) begin
            logic [3:0] a;
            a = 4'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                logic [3:0] s;
                s = ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom);
                wr_issue(a, $urandom, s, $urandom_range(3, 0), $urandom_range(3, 0));
                wr_finish($urandom_range(3, 0));
            end else begin
                rd(a, $urandom_range(3, 0));
            end
        end

        // Reset while a write response is pending.
        wr_issue(4'h0, 32'hA5A5_0F0F, 4'hF, 0, 0);
        @(negedge i_clk);
        #2 i_async_rst_n = 1'b0;
        #1;
        chk_eq("abort_bvalid", 32'(bus.bvalid), 32'd0);
        chk_eq("abort_awready", 32'(bus.awready), 32'd0);
        chk_eq("abort_ctrl", o_ctrl, 32'd0);
        m_ctrl = 32'h0;
        m_scratch = 32'h0;
        @(negedge i_clk);
        i_async_rst_n = 1'b1;
        clr_edge = edge_n;
        bus.bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk_eq("no_stale_b", 32'(bus.bvalid), 32'd0);
        end
        bus.bready = 1'b0;
        rd(4'h0, 0);
        rd(4'h4, 1);
        rd(4'h8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
